// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - 8-way round-robin arbiter with hold limit and encoded grant index
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       expired
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    state_t     state;
    logic [2:0] ptr;
    logic [7:0] cnt;
    logic [2:0] pick;
    logic       pick_ok;
    logic [2:0] idx;
    logic       hold_done;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = ptr;
        for (int k = 7; k >= 0; k--) begin
            idx = ptr + 3'(k);
            if (req[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign hold_done = (HOLD_LIMIT != 8'd0) && (cnt >= HOLD_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            cnt       <= 8'd0;
            gnt       <= 8'h00;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            expired   <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_ok) begin
                        gnt       <= 8'b1 << pick;
                        gnt_id    <= pick;
                        gnt_valid <= 1'b1;
                        cnt       <= 8'd1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id] || hold_done) begin
                        // gnt_id is left untouched so the last winner stays readable.
                        gnt       <= 8'h00;
                        gnt_valid <= 1'b0;
                        expired   <= req[gnt_id];
                        ptr       <= gnt_id + 3'd1;
                        state     <= IDLE;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - table, directed and random checks of rr_arbiter8 at three hold limits
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic [7:0] g  [3];
    logic [2:0] gi [3];
    logic       gv [3];
    logic       ge [3];
    logic       mon_en = 1'b0;
    int         n_err = 0;
    int         n_checks = 0;

    localparam int HL [3] = '{16, 4, 0};

    always #5 clk = ~clk;

    rr_arbiter8 u16 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(g[0]), .gnt_id(gi[0]),
                     .gnt_valid(gv[0]), .expired(ge[0]));
    rr_arbiter8 #(.MAX_HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(g[1]),
                     .gnt_id(gi[1]), .gnt_valid(gv[1]), .expired(ge[1]));
    rr_arbiter8 #(.MAX_HOLD(0)) u0 (.clk(clk), .rst_n(rst_n), .req(req), .gnt(g[2]),
                     .gnt_id(gi[2]), .gnt_valid(gv[2]), .expired(ge[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: owner index (-1 = none), cycles held, next-search start, last winner.
    int m_own [3] = '{-1, -1, -1};
    int m_id  [3] = '{0, 0, 0};
    int m_ptr [3] = '{0, 0, 0};
    int m_cnt [3] = '{0, 0, 0};
    bit m_exp [3] = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m_own[i] = -1; m_id[i] = 0; m_ptr[i] = 0; m_cnt[i] = 0; m_exp[i] = 0;
            end else begin
                m_exp[i] = 0;
                if (m_own[i] < 0) begin
                    for (int k = 0; k < 8; k++) begin
                        if (m_own[i] < 0 && req[(m_ptr[i] + k) % 8]) begin
                            m_own[i] = (m_ptr[i] + k) % 8;
                            m_id[i]  = m_own[i];
                            m_cnt[i] = 1;
                        end
                    end
                end else if (!req[m_own[i]]) begin
                    m_ptr[i] = (m_own[i] + 1) % 8;
                    m_own[i] = -1;
                end else if (HL[i] != 0 && m_cnt[i] >= HL[i]) begin
                    m_exp[i] = 1;
                    m_ptr[i] = (m_own[i] + 1) % 8;
                    m_own[i] = -1;
                end else begin
                    m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("mon%0d gnt", i), 32'(g[i]),
                    (m_own[i] < 0) ? 32'd0 : (32'd1 << m_own[i]));
                chk($sformatf("mon%0d gnt_id", i), 32'(gi[i]), 32'(m_id[i]));
                chk($sformatf("mon%0d gnt_valid", i), 32'(gv[i]), 32'(m_own[i] >= 0));
                chk($sformatf("mon%0d expired", i), 32'(ge[i]), 32'(m_exp[i]));
            end
        end
    end

    task automatic cyc(input logic [7:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [2:0] id;
        logic       v;
    } vec_t;

    vec_t tbl [13];
    logic [7:0] rr;

    initial begin
        tbl[0]  = '{8'h00, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{8'h08, 8'h08, 3'd3, 1'b1};
        tbl[2]  = '{8'h08, 8'h08, 3'd3, 1'b1};
        tbl[3]  = '{8'h0C, 8'h08, 3'd3, 1'b1};
        tbl[4]  = '{8'h04, 8'h00, 3'd3, 1'b0};
        tbl[5]  = '{8'h0C, 8'h04, 3'd2, 1'b1};
        tbl[6]  = '{8'h00, 8'h00, 3'd2, 1'b0};
        tbl[7]  = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[8]  = '{8'h01, 8'h00, 3'd7, 1'b0};
        tbl[9]  = '{8'h81, 8'h01, 3'd0, 1'b1};
        tbl[10] = '{8'h80, 8'h00, 3'd0, 1'b0};
        tbl[11] = '{8'h81, 8'h80, 3'd7, 1'b1};
        tbl[12] = '{8'h00, 8'h00, 3'd7, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("init gnt", 32'(g[i]), 0);
            chk("init gnt_id", 32'(gi[i]), 0);
            chk("init gnt_valid", 32'(gv[i]), 0);
            chk("init expired", 32'(ge[i]), 0);
        end
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int n = 0; n < 13; n++) begin
            cyc(tbl[n].r);
            chk($sformatf("tbl%0d gnt", n), 32'(g[0]), 32'(tbl[n].g));
            chk($sformatf("tbl%0d gnt_id", n), 32'(gi[0]), 32'(tbl[n].id));
            chk($sformatf("tbl%0d gnt_valid", n), 32'(gv[0]), 32'(tbl[n].v));
        end

        // Asynchronous reset in the middle of a grant.
        cyc(8'h08);
        cyc(8'h08);
        chk("pre-reset gnt", 32'(g[0]), 32'h08);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst gnt", 32'(g[0]), 0);
        chk("async rst gnt_valid", 32'(gv[0]), 0);
        chk("async rst gnt_id", 32'(gi[0]), 0);
        chk("async rst expired", 32'(ge[0]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(8'h04);
        chk("post-reset gnt", 32'(g[0]), 32'h04);
        chk("post-reset gnt_id", 32'(gi[0]), 2);
        cyc(8'h00);

        // Single requester held for five cycles.
        for (int n = 0; n < 5; n++) begin
            cyc(8'h08);
            chk("single gnt", 32'(g[0]), 32'h08);
            chk("single gnt_id", 32'(gi[0]), 3);
            chk("single expired", 32'(ge[0]), 0);
        end
        cyc(8'h00);
        chk("single drop gnt", 32'(g[0]), 0);
        chk("single drop expired", 32'(ge[0]), 0);

        // Full contention starting from ptr=0.
        cyc(8'h80);
        cyc(8'h00);
        for (int n = 0; n < 9; n++) begin
            cyc(8'hFF);
            chk("contention gnt_id", 32'(gi[0]), 32'(n % 8));
            chk("contention gnt_valid", 32'(gv[0]), 1);
            rr = 8'hFF & ~(8'h01 << (n % 8));
            cyc(rr);
            chk("contention bubble", 32'(gv[0]), 0);
        end

        // Wrap-around: ptr driven to 6, then 7 -> 0.
        cyc(8'h20);
        cyc(8'h00);
        cyc(8'h41);
        chk("wrap first gnt_id", 32'(gi[0]), 6);
        cyc(8'h01);
        chk("wrap release", 32'(gv[0]), 0);
        cyc(8'h01);
        chk("wrap second gnt_id", 32'(gi[0]), 0);
        chk("wrap second gnt", 32'(g[0]), 32'h01);
        cyc(8'h00);

        // Hold limit of 4 on u4.
        cyc(8'h04);
        chk("hold gnt c1", 32'(g[1]), 32'h04);
        for (int n = 2; n <= 4; n++) begin
            cyc(8'h24);
            chk($sformatf("hold gnt c%0d", n), 32'(g[1]), 32'h04);
            chk("hold expired low", 32'(ge[1]), 0);
        end
        cyc(8'h24);
        chk("hold expire gnt", 32'(g[1]), 0);
        chk("hold expire pulse", 32'(ge[1]), 1);
        cyc(8'h24);
        chk("hold next gnt", 32'(g[1]), 32'h20);
        chk("hold next gnt_id", 32'(gi[1]), 5);
        chk("hold pulse ended", 32'(ge[1]), 0);
        cyc(8'h04);
        chk("hold rel5", 32'(gv[1]), 0);
        cyc(8'h04);
        chk("hold regrant 2", 32'(g[1]), 32'h04);
        cyc(8'h00);

        // Unlimited hold on u0 over 300 cycles with a competitor waiting.
        cyc(8'h81);
        for (int n = 0; n < 300; n++) begin
            if (g[2] !== 8'h80 || ge[2] !== 1'b0) begin
                chk("unlimited gnt", 32'(g[2]), 32'h80);
                chk("unlimited expired", 32'(ge[2]), 0);
            end else begin
                n_checks++;
            end
            cyc(8'h81);
        end
        cyc(8'h01);
        chk("unlimited release", 32'(gv[2]), 0);
        cyc(8'h01);
        chk("unlimited next gnt_id", 32'(gi[2]), 0);
        chk("unlimited next gnt", 32'(g[2]), 32'h01);
        cyc(8'h00);

        // Random traffic against the reference model, with occasional async resets.
        rr = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) rr = 8'($urandom) & 8'($urandom);
            cyc(rr);
            if ($urandom_range(0, 60) == 0) begin
                #2 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter that shares one downstream resource among 8 requesters and reports the winner both one-hot and as a 3-bit binary index. It is the sequential front end to the 8x3 encoder datapath. Each requester drives a request line, the arbiter registers a single grant, and the winner is encoded for the resource select. The arbiter holds each grant until the requester releases it or a programmable hold limit expires, then rotates priority.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles a grant is held; legal range 0..255; 0 = unlimited.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req  in  8  request lines; req[i]=1 means requester i wants or keeps the resource
- gnt  out  8  one-hot grant, registered; all zero when nothing is granted
- gnt_id  out  3  binary index of granted requester (encoded gnt), registered
- gnt_valid  out  1  1 while any grant is active; equals |gnt
- expired  out  1  one-cycle pulse when a grant is forcibly ended by MAX_HOLD

## Operation
- Internal state:
  - FSM {IDLE, GRANT}
  - 3-bit priority pointer ptr
  - 8-bit hold counter cnt
- **IDLE:**
  - If req == 0, stay in IDLE.
  - Otherwise select the first i with req[i]=1, searching ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
  - Register gnt = 1<<i, gnt_id = i, gnt_valid = 1, cnt = 1, then go to GRANT.
- **GRANT, owner keeps the grant** (req[gnt_id]=1 and (MAX_HOLD==0 or cnt<MAX_HOLD)):
  - Stay in GRANT.
  - cnt increments and saturates at 255.
- **GRANT, owner releases** (req[gnt_id]=0):
  - Clear gnt and gnt_valid.
  - ptr = gnt_id+1 mod 8; go to IDLE.
  - gnt_id keeps its last value.
- **GRANT, hold limit reached** (req[gnt_id]=1 and MAX_HOLD≠0 and cnt==MAX_HOLD):
  - Clear gnt and gnt_valid; pulse expired=1 for one cycle.
  - ptr = gnt_id+1 mod 8; go to IDLE.
  - The owner may keep req high and competes again at lowest priority.
- Requests from non-owners never affect an active grant; there is no preemption.
- At most one gnt bit is ever set. gnt_id always equals the encoded gnt while gnt_valid=1.
- Encoding: gnt_id is the binary position of the single set bit in gnt. The priority search replaces the plain encoder's undefined behaviour for multiple active inputs.
- Wrap-around: ptr increments modulo 8. With ptr=7, the search order is 7, 0, 1, …, 6.
- MAX_HOLD=1: every grant lasts exactly one cycle. expired pulses whenever the owner is still requesting.

## Timing
- Reset (rst_n=0, asynchronous and immediate):
  - gnt=8'h00, gnt_id=3'd0, gnt_valid=0, expired=0.
  - ptr=0, cnt=0, state IDLE.
  - Reset asserted mid-grant drops gnt without waiting for a clock edge.
- First arbitration happens on the first rising edge after rst_n deasserts.
- Grant latency: a req sampled at edge k in IDLE gives gnt visible after edge k (registered; one cycle from req assertion).
- Release latency: req[owner] low at edge k gives gnt=0 after edge k.
- Gap between grants: the cycle after a release is always IDLE, so there is one bubble cycle. The next grant is registered at edge k+1. Consecutive owners are therefore separated by exactly one cycle with gnt_valid=0.
- With MAX_HOLD=M≠0, a continuously requesting owner holds gnt for exactly M cycles. expired is high during the first bubble cycle.
- expired is registered and never high while gnt_valid=1.
- Throughput: with all lines requesting and every owner releasing after one cycle, there is one grant every 2 cycles, visiting 0,1,…,7,0.

## Test plan
- **Reset:**
  - Stimulus: assert rst_n=0 mid-simulation while gnt=8'h08.
  - Required: gnt=0, gnt_valid=0, gnt_id=0, expired=0 immediately, without a clock edge. After release, req=8'h04 gives gnt=8'h04 and gnt_id=2 one edge later.
- **Single requester:**
  - Stimulus: req=8'h08 for 5 cycles, then 0.
  - Required: gnt=8'h08, gnt_id=3 for exactly 5 cycles, starting one edge after req. gnt=0 one edge after req drops. expired never pulses.
- **Full contention:**
  - Stimulus: req=8'hFF; each owner drops its bit for one cycle after being granted for 1 cycle.
  - Required: gnt_id sequence is 0,1,2,3,4,5,6,7,0 with one gnt_valid=0 cycle between grants.
- **Wrap-around:**
  - Stimulus: drive ptr to 6 by granting and releasing requester 5, then req=8'h41.
  - Required: first grant is gnt_id=6; after its release, gnt_id=0.
- **Hold limit:**
  - Stimulus: MAX_HOLD=4; req[2] held high permanently; req[5] raised 1 cycle after the grant to 2.
  - Required: gnt=8'h04 for exactly 4 cycles. expired=1 for one cycle with gnt=0. Then gnt=8'h20, gnt_id=5. Requester 2 is re-granted only after 5 releases.
- **Unlimited hold:**
  - Stimulus: MAX_HOLD=0; req[7] high for 300 cycles while req[0] is also high.
  - Required: gnt=8'h80 for all 300 cycles; expired stays 0. After release, gnt_id=0.
